// File: rtl/sa_feed_pkg.sv
// Shared types and constants for the 3x3 systolic-array feeder.
// Configuration macro: SA_FEED_WREUSE_EN (weight reuse, see sa_feeder_3x3).
package sa_feed_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADW  = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    localparam int DW_DEF    = 8;
    localparam int N_DEF     = 3;
    localparam int DRAIN_DEF = 3;

    function automatic int elem_idx(input int r, input int k, input int n = N_DEF);
        return r * n + k;
    endfunction

    // Counter must reach the longest phase: 2N-1 stream steps or DRAIN drain cycles.
    function automatic int cnt_width(input int n, input int drain);
        int cmax;
        cmax = 2 * n - 2;
        if (drain - 1 > cmax) cmax = drain - 1;
        return (cmax < 1) ? 1 : $clog2(cmax + 1);
    endfunction

endpackage

// File: rtl/sa_feeder_3x3_if.sv
// Tile input handshake for the feeder: valid/ready plus the W and X matrices.
// With SA_FEED_WREUSE_EN defined, s_keep_w travels with the tile.
interface sa_feeder_3x3_if #(
    parameter int DW = sa_feed_pkg::DW_DEF,
    parameter int N  = sa_feed_pkg::N_DEF
);
    logic              s_valid;
    logic              s_ready;
    logic [N*N*DW-1:0] s_w;
    logic [N*N*DW-1:0] s_x;
`ifdef SA_FEED_WREUSE_EN
    logic              s_keep_w;

    modport master (output s_valid, s_w, s_x, s_keep_w, input s_ready);
    modport slave  (input s_valid, s_w, s_x, s_keep_w, output s_ready);
`else
    modport master (output s_valid, s_w, s_x, input s_ready);
    modport slave  (input s_valid, s_w, s_x, output s_ready);
`endif
endinterface

// File: rtl/sa_feed_skew.sv
// Combinational diagonal skew: lane k carries X[t-k][k] while 0 <= t-k < N, else 0.
module sa_feed_skew #(
    parameter int DW = 8,
    parameter int N  = 3,
    parameter int CW = 3
) (
    input  logic [N*N*DW-1:0] x,
    input  logic [CW-1:0]     t,
    output logic [N*DW-1:0]   a
);
    import sa_feed_pkg::*;

    localparam int RW = (N > 1) ? $clog2(N) : 1;

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic [DW-1:0] col [N];
        logic [CW-1:0] r;
        logic          in_rng;

        for (genvar gj = 0; gj < N; gj++) begin : g_col
            assign col[gj] = x[elem_idx(gj, gi, N)*DW +: DW];
        end

        // Row feeding this lane at step t is t-gi; guard both ends before indexing.
        assign r      = t - CW'(gi);
        assign in_rng = (t >= CW'(gi)) && (r < CW'(N));
        assign a[gi*DW +: DW] = in_rng ? col[r[RW-1:0]] : '0;
    end

endmodule

// File: rtl/sa_feeder_3x3.sv
// Feeder for the 3x3 weight-stationary array: preloads W row by row, then streams skewed X.
// SA_FEED_WREUSE_EN: s_keep_w lets a tile reuse the previously loaded weights.
module sa_feeder_3x3 #(
    parameter int DW    = sa_feed_pkg::DW_DEF,
    parameter int N     = sa_feed_pkg::N_DEF,
    parameter int DRAIN = sa_feed_pkg::DRAIN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    sa_feeder_3x3_if.slave  s,
    output logic [N*DW-1:0] b_out,
    output logic            p1_en,
    output logic [N*DW-1:0] a_out,
    output logic            busy,
    output logic            done
);
    import sa_feed_pkg::*;

    localparam int CW = cnt_width(N, DRAIN);
    localparam int RW = (N > 1) ? $clog2(N) : 1;

    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [N*N*DW-1:0] w_reg, x_reg;
    logic [N*N*DW-1:0] tile_w, tile_x;
    logic              accept;
    logic              done_next;
    logic [N*DW-1:0]   b_next, a_next, skew_a;
    logic [N*DW-1:0]   w_rows [N];
`ifdef SA_FEED_WREUSE_EN
    logic              w_loaded_reg, w_loaded_next;
`endif

    assign s.s_ready = (state_reg == IDLE);
    assign accept    = s.s_valid && (state_reg == IDLE);

    // Outputs are registered from the next state, so the tile being accepted
    // must be visible before it lands in w_reg/x_reg.
    assign tile_w = accept ? s.s_w : w_reg;
    assign tile_x = accept ? s.s_x : x_reg;

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        assign w_rows[gi] = tile_w[elem_idx(gi, 0, N)*DW +: N*DW];
    end

    sa_feed_skew #(
        .DW (DW),
        .N  (N),
        .CW (CW)
    ) u_skew (
        .x (tile_x),
        .t (cnt_next),
        .a (skew_a)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        done_next  = 1'b0;
`ifdef SA_FEED_WREUSE_EN
        w_loaded_next = w_loaded_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    cnt_next   = '0;
                    state_next = LOADW;
`ifdef SA_FEED_WREUSE_EN
                    if (s.s_keep_w && w_loaded_reg) state_next = STREAM;
`endif
                end
            end
            LOADW: begin
                if (cnt_reg == CW'(N - 1)) begin
                    state_next = STREAM;
                    cnt_next   = '0;
`ifdef SA_FEED_WREUSE_EN
                    w_loaded_next = 1'b1;
`endif
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            STREAM: begin
                if (cnt_reg == CW'(2 * N - 2)) begin
                    state_next = sa_feed_pkg::DRAIN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            sa_feed_pkg::DRAIN: begin
                if (cnt_reg == CW'(DRAIN - 1)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        b_next = '0;
        a_next = '0;
        if (state_next == LOADW)  b_next = w_rows[cnt_next[RW-1:0]];
        if (state_next == STREAM) a_next = skew_a;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            w_reg     <= '0;
            x_reg     <= '0;
            b_out     <= '0;
            a_out     <= '0;
            p1_en     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                w_reg <= s.s_w;
                x_reg <= s.s_x;
            end
            b_out <= b_next;
            a_out <= a_next;
            p1_en <= (state_next == LOADW);
            busy  <= (state_next != IDLE);
            done  <= done_next;
        end
    end

`ifdef SA_FEED_WREUSE_EN
    always_ff @(posedge clk) begin
        if (!rst) w_loaded_reg <= 1'b0;
        else      w_loaded_reg <= w_loaded_next;
    end
`endif

endmodule

// File: tb/tb_sa_feeder_3x3.sv
// Directed bench for sa_feeder_3x3: reset, preload/stream timing, back-to-back, abort,
// and (with SA_FEED_WREUSE_EN) weight reuse.
module tb_sa_feeder_3x3;
    localparam int DW = 8;
    localparam int N  = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N*DW-1:0] b_out, a_out;
    logic            p1_en, busy, done;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // Tile A: W = 1..9 row-major, X = diag(1,2,3)
    localparam logic [71:0]  WA  = 72'h090807060504030201;
    localparam logic [71:0]  XA  = 72'h030000000200000001;
    localparam logic [71:0]  BA  = {24'h090807, 24'h060504, 24'h030201};
    localparam logic [119:0] AA  = {24'h030000, 24'h000000, 24'h000200, 24'h000000, 24'h000001};
    // Tile B: W[r][k] = 0x40+r*3+k, X[r][k] = 0x10*(r+1)+(k+1)
    localparam logic [71:0]  WB  = 72'h484746454443424140;
    localparam logic [71:0]  XB  = 72'h333231232221131211;
    localparam logic [71:0]  BB  = {24'h484746, 24'h454443, 24'h424140};
    localparam logic [119:0] AB  = {24'h330000, 24'h233200, 24'h132231, 24'h001221, 24'h000011};

    sa_feeder_3x3_if #(.DW(DW), .N(N)) bus ();

    sa_feeder_3x3 #(.DW(DW), .N(N), .DRAIN(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .s     (bus.slave),
        .b_out (b_out),
        .p1_en (p1_en),
        .a_out (a_out),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=%06h expected=%06h", tag, obs, exp);
        end
    endtask

    task automatic step_chk(input string tag, input logic ep1, input logic [23:0] eb,
                            input logic [23:0] ea, input logic ebusy, input logic edone,
                            input logic erdy);
        chk({tag, ".p1_en"},   {23'd0, p1_en},       {23'd0, ep1});
        chk({tag, ".b_out"},   b_out,                eb);
        chk({tag, ".a_out"},   a_out,                ea);
        chk({tag, ".busy"},    {23'd0, busy},        {23'd0, ebusy});
        chk({tag, ".done"},    {23'd0, done},        {23'd0, edone});
        chk({tag, ".s_ready"}, {23'd0, bus.s_ready}, {23'd0, erdy});
    endtask

    // Entered one cycle after the accept edge; returns in the done cycle.
    task automatic run_tile(input string tag, input logic loadw, input logic [71:0] bv,
                            input logic [119:0] av);
        logic [71:0]  bs;
        logic [119:0] as_v;
        int f0;
        bs   = bv;
        as_v = av;
        f0   = failed;
        if (loadw) begin
            for (int i = 0; i < 3; i++) begin
                step_chk($sformatf("%s.load%0d", tag, i), 1'b1, bs[23:0], 24'h0, 1'b1, 1'b0, 1'b0);
                bs = bs >> 24;
                tick();
            end
        end
        for (int t = 0; t < 5; t++) begin
            step_chk($sformatf("%s.stream%0d", tag, t), 1'b0, 24'h0, as_v[23:0], 1'b1, 1'b0, 1'b0);
            as_v = as_v >> 24;
            tick();
        end
        for (int d = 0; d < 3; d++) begin
            step_chk($sformatf("%s.drain%0d", tag, d), 1'b0, 24'h0, 24'h0, 1'b1, 1'b0, 1'b0);
            tick();
        end
        step_chk({tag, ".done"}, 1'b0, 24'h0, 24'h0, 1'b0, 1'b1, 1'b1);
        $display("tile %s loadw=%0d new_failures=%0d", tag, loadw, failed - f0);
    endtask

    initial begin
        int flag_seen;
        bus.s_valid = 1'b0;
        bus.s_w     = '0;
        bus.s_x     = '0;
`ifdef SA_FEED_WREUSE_EN
        bus.s_keep_w = 1'b0;
`endif

        // Reset held for two edges, then released with no tile offered
        tick();
        tick();
        step_chk("reset", 1'b0, 24'h0, 24'h0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        step_chk("post_reset0", 1'b0, 24'h0, 24'h0, 1'b0, 1'b0, 1'b1);
        tick();
        step_chk("post_reset1", 1'b0, 24'h0, 24'h0, 1'b0, 1'b0, 1'b1);

        // Tile A accepted; s_valid stays high with tile B on the bus while busy
        bus.s_valid = 1'b1;
        bus.s_w     = WA;
        bus.s_x     = XA;
        tick();
        bus.s_w = WB;
        bus.s_x = XB;
        run_tile("A", 1'b1, BA, AA);

        // Back-to-back: B accepted in A's done cycle
        tick();
        bus.s_valid = 1'b0;
        run_tile("B", 1'b1, BB, AB);
        tick();
        step_chk("idle_after_B", 1'b0, 24'h0, 24'h0, 1'b0, 1'b0, 1'b1);

        // Abort in the middle of streaming
        bus.s_valid = 1'b1;
        bus.s_w     = WB;
        bus.s_x     = XB;
        tick();
        bus.s_valid = 1'b0;
        step_chk("abort.load0", 1'b1, 24'h424140, 24'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        step_chk("abort.stream2", 1'b0, 24'h0, 24'h132231, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        step_chk("abort.reset", 1'b0, 24'h0, 24'h0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        flag_seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done || busy) flag_seen = 1;
        end
        chk("abort.no_done_or_busy", 24'(flag_seen), 24'h0);
        $display("abort check done_or_busy_seen=%0d", flag_seen);

        // Fresh tile after the abort; with weight reuse enabled keep_w must not skip here
        bus.s_valid = 1'b1;
        bus.s_w     = WA;
        bus.s_x     = XA;
`ifdef SA_FEED_WREUSE_EN
        bus.s_keep_w = 1'b1;
`endif
        tick();
        bus.s_valid = 1'b0;
        run_tile("A2", 1'b1, BA, AA);

`ifdef SA_FEED_WREUSE_EN
        // Weights now loaded: keep_w skips the preload entirely
        bus.s_valid  = 1'b1;
        bus.s_w      = WB;
        bus.s_x      = XB;
        bus.s_keep_w = 1'b1;
        tick();
        bus.s_valid  = 1'b0;
        bus.s_keep_w = 1'b0;
        run_tile("B_reuse", 1'b0, BB, AB);
`endif

        tick();
        step_chk("final_idle", 1'b0, 24'h0, 24'h0, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
